// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared FSM states, accumulator sizing and saturation helper for
//            the matrix_mac_engine datapath.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2,
        ST_FIN  = 2'd3
    } mac_state_t;

    localparam int C_DEF_DATA_WIDTH = 8;
    localparam int C_DEF_N          = 3;

    // Headroom of $clog2(N) bits lets N full-precision products sum without wrap.
    function automatic int acc_width(input int data_width, input int n);
        return 2 * data_width + $clog2(n);
    endfunction

    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    localparam int                 C_ACC_WIDTH = acc_width(C_DEF_DATA_WIDTH, C_DEF_N);
    localparam logic signed [63:0] C_SAT_MAX   = sat_max(2 * C_DEF_DATA_WIDTH);
    localparam logic signed [63:0] C_SAT_MIN   = sat_min(2 * C_DEF_DATA_WIDTH);

    // Operates on a sign-extended 64-bit copy; caller keeps the low res_width bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] acc,
                                                    input int                 res_width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = sat_max(res_width);
        lo = sat_min(res_width);
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : mac_unit
// Purpose  : Signed multiply-accumulate register with clear, enable and a
//            saturated result view.
// Revision : 1.0 - initial release
// ============================================================================
module mac_unit
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = C_ACC_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic signed [DATA_WIDTH-1:0]  a,
    input  logic signed [DATA_WIDTH-1:0]  b,
    output logic signed [2*DATA_WIDTH-1:0] result
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [63:0]             acc_ext;
    logic signed [63:0]             acc_sat;

    // Clear has priority so a new element never inherits a stale sum.
    always_comb begin
        prod  = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_comb begin
        acc_ext = 64'(acc_q);
        acc_sat = saturate(acc_ext, 2 * DATA_WIDTH);
        result  = acc_sat[2*DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mac_engine
// Purpose  : Sequential signed C = A x B with one MAC, streaming C row-major
//            over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_mac_engine
    import matrix_pkg::*;
#(
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           a_wen,
    input  logic [$clog2(M*N)-1:0]         a_addr,
    input  logic signed [DATA_WIDTH-1:0]   a_data,
    input  logic                           b_wen,
    input  logic [$clog2(N*P)-1:0]         b_addr,
    input  logic signed [DATA_WIDTH-1:0]   b_data,
    input  logic                           start,
    input  logic                           matrix_ready,
    output logic signed [2*DATA_WIDTH-1:0] matrix_result,
    output logic                           matrix_valid,
    output logic [$clog2(M)-1:0]           result_row,
    output logic [$clog2(P)-1:0]           result_col,
    output logic                           busy,
    output logic                           done
);

    localparam int ACC_W = acc_width(DATA_WIDTH, N);
    localparam int A_AW  = $clog2(M*N);
    localparam int B_AW  = $clog2(N*P);
    localparam int RW    = $clog2(M);
    localparam int CW    = $clog2(P);
    localparam int KW    = $clog2(N);

    mac_state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] a_mem_q [M*N];
    logic signed [DATA_WIDTH-1:0] a_mem_d [M*N];
    logic signed [DATA_WIDTH-1:0] b_mem_q [N*P];
    logic signed [DATA_WIDTH-1:0] b_mem_d [N*P];

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [KW-1:0] k_q,   k_d;

    logic                         mac_clr;
    logic                         mac_en;
    logic [A_AW-1:0]              a_rd_idx;
    logic [B_AW-1:0]              b_rd_idx;
    logic signed [DATA_WIDTH-1:0] mac_a;
    logic signed [DATA_WIDTH-1:0] mac_b;
    logic                         last_elem;

    // Storage is writable only while idle; stray addresses are dropped.
    always_comb begin
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        if (state_q == ST_IDLE) begin
            if (a_wen && (int'(a_addr) < M*N)) begin
                a_mem_d[a_addr] = a_data;
            end
            if (b_wen && (int'(b_addr) < N*P)) begin
                b_mem_d[b_addr] = b_data;
            end
        end
    end

    always_comb begin
        a_rd_idx = A_AW'(int'(row_q) * N + int'(k_q));
        b_rd_idx = B_AW'(int'(k_q) * P + int'(col_q));
        mac_a    = a_mem_q[a_rd_idx];
        mac_b    = b_mem_q[b_rd_idx];
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        k_d       = k_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        last_elem = (row_q == RW'(M-1)) && (col_q == CW'(P-1));
        case (state_q)
            ST_IDLE: begin
                mac_clr = 1'b1;
                row_d   = '0;
                col_d   = '0;
                k_d     = '0;
                if (start) begin
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (k_q == KW'(N-1)) begin
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_OUT: begin
                // Accumulator and tags stay frozen until the element is taken.
                if (matrix_ready) begin
                    if (last_elem) begin
                        state_d = ST_FIN;
                    end else begin
                        mac_clr = 1'b1;
                        k_d     = '0;
                        state_d = ST_MAC;
                        if (col_q == CW'(P-1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            for (int i = 0; i < M*N; i++) begin
                a_mem_q[i] <= '0;
            end
            for (int i = 0; i < N*P; i++) begin
                b_mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            a_mem_q <= a_mem_d;
            b_mem_q <= b_mem_d;
        end
    end

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mac_clr),
        .en     (mac_en),
        .a      (mac_a),
        .b      (mac_b),
        .result (matrix_result)
    );

    assign matrix_valid = (state_q == ST_OUT);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FIN);
    assign result_row   = row_q;
    assign result_col   = col_q;

endmodule
`default_nettype wire
